// File: rtl/scr1_ahb_memory.sv
// Simulation memory with two AHB-Lite slave ports over one shared little-endian byte array.
//
// The instruction port (imem_*) is read-only. The data port (dmem_*) reads and writes the array,
// and also decodes a small register window:
//   0xF0000000  print sink (writes dropped, reads 0)
//   0xF0000100  external IRQ register -> ext_irq (bit 0) or irq_lines
//   0xF0000200  software IRQ register -> soft_irq (bit 0)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   irq_lines / ext_irq, soft_irq  registered interrupt outputs
//   *_req_ack_stall_in             per-port wait-state patterns (bit set = wait cycle)
//   imem_hsize/htrans/haddr        instruction address phase
//   imem_hready/hrdata/hresp       instruction data-phase response
//   dmem_hsize/htrans/haddr/hwrite data address phase; dmem_hwdata in the data phase
//   dmem_hready/hrdata/hresp       data data-phase response
//
// Build option: define SCR1_IPIC_EN to replace ext_irq with the irq_lines bus.
module scr1_ahb_memory #(
  parameter int unsigned SCR1_MEM_POWER_SIZE = 16,
  parameter int unsigned SCR1_AHB_WIDTH      = 32,
  parameter int unsigned SCR1_IRQ_LINES_NUM  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef SCR1_IPIC_EN
  output logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines,
`else
  output logic                          ext_irq,
`endif
  output logic                          soft_irq,
  input  logic [31:0]                   imem_req_ack_stall_in,
  input  logic [31:0]                   dmem_req_ack_stall_in,
  input  logic [2:0]                    imem_hsize,
  input  logic [1:0]                    imem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0]     imem_haddr,
  output logic                          imem_hready,
  output logic [SCR1_AHB_WIDTH-1:0]     imem_hrdata,
  output logic                          imem_hresp,
  input  logic [2:0]                    dmem_hsize,
  input  logic [1:0]                    dmem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0]     dmem_haddr,
  input  logic                          dmem_hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0]     dmem_hwdata,
  output logic                          dmem_hready,
  output logic [SCR1_AHB_WIDTH-1:0]     dmem_hrdata,
  output logic                          dmem_hresp
);

  localparam int unsigned AW = SCR1_MEM_POWER_SIZE;
  localparam int unsigned W  = SCR1_AHB_WIDTH;

`ifdef SCR1_IPIC_EN
  localparam int unsigned ExtW = SCR1_IRQ_LINES_NUM;
`else
  localparam int unsigned ExtW = 1;
`endif

  localparam logic [31:0] AddrPrint = 32'hF000_0000;
  localparam logic [31:0] AddrExt   = 32'hF000_0100;
  localparam logic [31:0] AddrSoft  = 32'hF000_0200;

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} port_st_e;

  // Unsupported size or address not aligned to the transfer size.
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
    logic err;
    err = 1'b0;
    if (size > 3'd2)       err = 1'b1;
    else if (size == 3'd1) err = lsb[0];
    else if (size == 3'd2) err = (lsb != 2'b00);
    return err;
  endfunction

  logic [7:0] mem_q [2**AW];

  // ---------------------------------------------------------------------------------------------
  // Instruction port
  // ---------------------------------------------------------------------------------------------
  port_st_e      imem_st_q, imem_st_d;
  logic [AW-3:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]   imem_pat_q, imem_pat_d;
  logic          imem_wait;
  logic [31:0]   imem_word;

  always_comb begin
    // All-ones pattern means no waits at all rather than an endless stall.
    imem_wait    = (imem_st_q == StData) && imem_pat_q[0] && (imem_pat_q != '1);
    imem_hready  = !imem_wait && (imem_st_q != StErr1);
    imem_hresp   = (imem_st_q == StErr1) || (imem_st_q == StErr2);
    imem_st_d    = StIdle;
    imem_waddr_d = imem_waddr_q;
    imem_pat_d   = imem_wait ? {imem_pat_q[0], imem_pat_q[31:1]} : imem_req_ack_stall_in;
    if (imem_htrans[1] && imem_hready) begin
      imem_waddr_d = imem_haddr[AW-1:2];
      imem_st_d    = size_err(imem_hsize, imem_haddr[1:0]) ? StErr1 : StData;
    end else if (imem_wait) begin
      imem_st_d = StData;
    end else if (imem_st_q == StErr1) begin
      imem_st_d = StErr2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_st_q    <= StIdle;
      imem_waddr_q <= '0;
      imem_pat_q   <= '0;
    end else begin
      imem_st_q    <= imem_st_d;
      imem_waddr_q <= imem_waddr_d;
      imem_pat_q   <= imem_pat_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------------------------------
  port_st_e      dmem_st_q, dmem_st_d;
  logic [W-1:0]  dmem_addr_q, dmem_addr_d;
  logic [2:0]    dmem_size_q, dmem_size_d;
  logic          dmem_write_q, dmem_write_d;
  logic [31:0]   dmem_pat_q, dmem_pat_d;
  logic          dmem_wait;
  logic          dmem_commit;
  logic          dmem_mem_wr;
  logic [3:0]    dmem_be;
  logic          sel_print, sel_ext, sel_soft;
  logic [31:0]   dmem_word;
  logic [31:0]   ext_rd;
  logic [ExtW-1:0] ext_q, ext_d;
  logic          soft_q, soft_d;

  always_comb begin
    dmem_wait    = (dmem_st_q == StData) && dmem_pat_q[0] && (dmem_pat_q != '1);
    dmem_hready  = !dmem_wait && (dmem_st_q != StErr1);
    dmem_hresp   = (dmem_st_q == StErr1) || (dmem_st_q == StErr2);
    dmem_st_d    = StIdle;
    dmem_addr_d  = dmem_addr_q;
    dmem_size_d  = dmem_size_q;
    dmem_write_d = dmem_write_q;
    dmem_pat_d   = dmem_wait ? {dmem_pat_q[0], dmem_pat_q[31:1]} : dmem_req_ack_stall_in;
    if (dmem_htrans[1] && dmem_hready) begin
      dmem_addr_d  = dmem_haddr;
      dmem_size_d  = dmem_hsize;
      dmem_write_d = dmem_hwrite;
      dmem_st_d    = size_err(dmem_hsize, dmem_haddr[1:0]) ? StErr1 : StData;
    end else if (dmem_wait) begin
      dmem_st_d = StData;
    end else if (dmem_st_q == StErr1) begin
      dmem_st_d = StErr2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_st_q    <= StIdle;
      dmem_addr_q  <= '0;
      dmem_size_q  <= '0;
      dmem_write_q <= 1'b0;
      dmem_pat_q   <= '0;
    end else begin
      dmem_st_q    <= dmem_st_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_size_q  <= dmem_size_d;
      dmem_write_q <= dmem_write_d;
      dmem_pat_q   <= dmem_pat_d;
    end
  end

  always_comb begin
    case (dmem_size_q)
      3'd0:    dmem_be = 4'b0001 << dmem_addr_q[1:0];
      3'd1:    dmem_be = dmem_addr_q[1] ? 4'b1100 : 4'b0011;
      default: dmem_be = 4'b1111;
    endcase
  end

  // Register window is decoded on the full address, so it shadows the aliased array bytes.
  assign sel_print   = (dmem_addr_q[W-1:2] == AddrPrint[W-1:2]);
  assign sel_ext     = (dmem_addr_q[W-1:2] == AddrExt[W-1:2]);
  assign sel_soft    = (dmem_addr_q[W-1:2] == AddrSoft[W-1:2]);
  assign dmem_commit = (dmem_st_q == StData) && !dmem_wait && dmem_write_q;
  assign dmem_mem_wr = dmem_commit && !(sel_print || sel_ext || sel_soft);

  always_ff @(posedge clk) begin
    if (dmem_mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) mem_q[{dmem_addr_q[AW-1:2], 2'(i)}] <= dmem_hwdata[8*i +: 8];
      end
    end
  end

  // Array reads; the imem path forwards a dmem write landing on the same word this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dmem_word[8*i +: 8] = mem_q[{dmem_addr_q[AW-1:2], 2'(i)}];
      if (dmem_mem_wr && dmem_be[i] && (dmem_addr_q[AW-1:2] == imem_waddr_q)) begin
        imem_word[8*i +: 8] = dmem_hwdata[8*i +: 8];
      end else begin
        imem_word[8*i +: 8] = mem_q[{imem_waddr_q, 2'(i)}];
      end
    end
  end

  always_comb begin
    ext_rd            = '0;
    ext_rd[ExtW-1:0]  = ext_q;
    ext_d             = ext_q;
    for (int unsigned j = 0; j < ExtW; j++) begin
      if (dmem_be[j/8]) ext_d[j] = dmem_hwdata[j];
    end
    soft_d = dmem_be[0] ? dmem_hwdata[0] : soft_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q  <= '0;
      soft_q <= 1'b0;
    end else begin
      if (dmem_commit && sel_ext)  ext_q  <= ext_d;
      if (dmem_commit && sel_soft) soft_q <= soft_d;
    end
  end

  always_comb begin
    imem_hrdata = '0;
    dmem_hrdata = '0;
    if (imem_st_q == StData) imem_hrdata = imem_word;
    if ((dmem_st_q == StData) && !dmem_write_q) begin
      if (sel_ext)        dmem_hrdata = ext_rd;
      else if (sel_soft)  dmem_hrdata = {31'd0, soft_q};
      else if (sel_print) dmem_hrdata = '0;
      else                dmem_hrdata = dmem_word;
    end
  end

`ifdef SCR1_IPIC_EN
  assign irq_lines = ext_q;
`else
  assign ext_irq   = ext_q[0];
`endif
  assign soft_irq  = soft_q;

  logic unused_bits;
  assign unused_bits = ^{imem_haddr[W-1:AW], imem_htrans[0], dmem_htrans[0]};

endmodule

// File: tb/tb_scr1_ahb_memory.sv
module tb_scr1_ahb_memory;

  localparam int MaxWaits = 40;

  logic        clk = 1'b0;
  logic        rst;
`ifdef SCR1_IPIC_EN
  logic [15:0] irq_lines;
  logic        ext_irq;
  assign ext_irq = irq_lines[0];
`else
  logic        ext_irq;
`endif
  logic        soft_irq;
  logic [31:0] imem_stall, dmem_stall;
  logic [2:0]  imem_hsize, dmem_hsize;
  logic [1:0]  imem_htrans, dmem_htrans;
  logic [31:0] imem_haddr, dmem_haddr, dmem_hwdata;
  logic        dmem_hwrite;
  logic        imem_hready, imem_hresp, dmem_hready, dmem_hresp;
  logic [31:0] imem_hrdata, dmem_hrdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  scr1_ahb_memory #(
    .SCR1_MEM_POWER_SIZE(16),
    .SCR1_AHB_WIDTH     (32),
    .SCR1_IRQ_LINES_NUM (16)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
`ifdef SCR1_IPIC_EN
    .irq_lines            (irq_lines),
`else
    .ext_irq              (ext_irq),
`endif
    .soft_irq             (soft_irq),
    .imem_req_ack_stall_in(imem_stall),
    .dmem_req_ack_stall_in(dmem_stall),
    .imem_hsize           (imem_hsize),
    .imem_htrans          (imem_htrans),
    .imem_haddr           (imem_haddr),
    .imem_hready          (imem_hready),
    .imem_hrdata          (imem_hrdata),
    .imem_hresp           (imem_hresp),
    .dmem_hsize           (dmem_hsize),
    .dmem_htrans          (dmem_htrans),
    .dmem_haddr           (dmem_haddr),
    .dmem_hwrite          (dmem_hwrite),
    .dmem_hwdata          (dmem_hwdata),
    .dmem_hready          (dmem_hready),
    .dmem_hrdata          (dmem_hrdata),
    .dmem_hresp           (dmem_hresp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One dmem transfer: address phase, then data phase sampled on falling edges.
  task automatic d_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int waits, output logic [31:0] rdata,
                        output logic resp0, output logic resp1);
    @(negedge clk);
    dmem_htrans = 2'b10; dmem_haddr = addr; dmem_hsize = size; dmem_hwrite = wr;
    @(posedge clk); #1;
    dmem_htrans = 2'b00; dmem_hwdata = wdata;
    @(negedge clk);
    resp0 = dmem_hresp;
    waits = 0;
    while (dmem_hready !== 1'b1 && waits < MaxWaits) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= MaxWaits) check("dmem_timeout", 32'(dmem_hready), 32'd1);
    rdata = dmem_hrdata;
    resp1 = dmem_hresp;
  endtask

  task automatic i_xfer(input logic [31:0] addr, input logic [2:0] size, output int waits,
                        output logic [31:0] rdata, output logic resp0, output logic resp1);
    @(negedge clk);
    imem_htrans = 2'b10; imem_haddr = addr; imem_hsize = size;
    @(posedge clk); #1;
    imem_htrans = 2'b00;
    @(negedge clk);
    resp0 = imem_hresp;
    waits = 0;
    while (imem_hready !== 1'b1 && waits < MaxWaits) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= MaxWaits) check("imem_timeout", 32'(imem_hready), 32'd1);
    rdata = imem_hrdata;
    resp1 = imem_hresp;
  endtask

  task automatic d_write(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input int exp_waits);
    int w; logic [31:0] rd; logic r0, r1;
    d_xfer(1'b1, addr, size, wdata, w, rd, r0, r1);
    check({tag, "_waits"}, 32'(w), 32'(exp_waits));
    check({tag, "_resp"}, 32'(r1), 32'd0);
  endtask

  task automatic d_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input int exp_waits);
    int w; logic [31:0] rd; logic r0, r1;
    exp_q.push_back(exp);
    d_xfer(1'b0, addr, 3'd2, 32'd0, w, rd, r0, r1);
    check({tag, "_data"}, rd, exp_q.pop_front());
    check({tag, "_waits"}, 32'(w), 32'(exp_waits));
    check({tag, "_resp"}, 32'(r1), 32'd0);
  endtask

  task automatic d_err(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size);
    int w; logic [31:0] rd; logic r0, r1;
    d_xfer(wr, addr, size, 32'hFFFF_FFFF, w, rd, r0, r1);
    check({tag, "_cyc1_hready0"}, 32'(w), 32'd1);
    check({tag, "_cyc1_hresp"}, 32'(r0), 32'd1);
    check({tag, "_cyc2_hresp"}, 32'(r1), 32'd1);
  endtask

  task automatic i_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input int exp_waits);
    int w; logic [31:0] rd; logic r0, r1;
    exp_q.push_back(exp);
    i_xfer(addr, 3'd2, w, rd, r0, r1);
    check({tag, "_data"}, rd, exp_q.pop_front());
    check({tag, "_waits"}, 32'(w), 32'(exp_waits));
    check({tag, "_resp"}, 32'(r1), 32'd0);
  endtask

  initial begin
    int w; logic [31:0] rd; logic r0, r1;
    rst = 1'b1;
    imem_stall = '0; dmem_stall = '0;
    imem_hsize = 3'd2; imem_htrans = 2'b00; imem_haddr = '0;
    dmem_hsize = 3'd2; dmem_htrans = 2'b00; dmem_haddr = '0; dmem_hwrite = 1'b0;
    dmem_hwdata = '0;
    repeat (2) @(negedge clk);
    check("rst_imem_hready", 32'(imem_hready), 32'd1);
    check("rst_imem_hresp", 32'(imem_hresp), 32'd0);
    check("rst_imem_hrdata", imem_hrdata, 32'd0);
    check("rst_dmem_hready", 32'(dmem_hready), 32'd1);
    check("rst_dmem_hresp", 32'(dmem_hresp), 32'd0);
    check("rst_dmem_hrdata", dmem_hrdata, 32'd0);
    check("rst_soft_irq", 32'(soft_irq), 32'd0);
    check("rst_ext_irq", 32'(ext_irq), 32'd0);
    rst = 1'b0;

    // Instruction fetch with no waits.
    d_write("pre_200", 32'h200, 3'd2, 32'h0000_0013, 0);
    i_read("imem_200", 32'h200, 32'h0000_0013, 0);

    // Wait states from pattern 0b0111.
    dmem_stall = 32'h7;
    d_write("wr_1000_stall", 32'h1000, 3'd2, 32'hDEAD_BEEF, 3);
    d_read("rd_1000_stall", 32'h1000, 32'hDEAD_BEEF, 3);
    dmem_stall = 32'h0;

    // Byte-lane writes.
    d_write("wr_base", 32'h1000, 3'd2, 32'h1122_3344, 0);
    d_write("wr_byte", 32'h1002, 3'd0, 32'h00AB_0000, 0);
    d_read("rd_byte", 32'h1000, 32'h11AB_3344, 0);
    d_write("wr_half", 32'h1000, 3'd1, 32'h0000_CAFE, 0);
    d_read("rd_half", 32'h1000, 32'h11AB_CAFE, 0);

    // Error responses, with no write side effect.
    d_err("err_half_rd", 1'b0, 32'h1001, 3'd1);
    d_err("err_word_wr", 1'b1, 32'h1002, 3'd2);
    d_err("err_size3_wr", 1'b1, 32'h1000, 3'd3);
    d_read("rd_after_err", 32'h1000, 32'h11AB_CAFE, 0);
    i_xfer(32'h202, 3'd2, w, rd, r0, r1);
    check("imem_err_hready0", 32'(w), 32'd1);
    check("imem_err_hresp", 32'({r0, r1}), 32'd3);

    // Interrupt registers.
    d_write("wr_soft", 32'hF000_0200, 3'd2, 32'h1, 0);
    check("soft_irq_at_commit", 32'(soft_irq), 32'd0);
    @(negedge clk);
    check("soft_irq_next", 32'(soft_irq), 32'd1);
    d_write("wr_ext", 32'hF000_0100, 3'd2, 32'h1, 0);
    check("ext_irq_at_commit", 32'(ext_irq), 32'd0);
    @(negedge clk);
    check("ext_irq_next", 32'(ext_irq), 32'd1);
    d_read("rd_soft", 32'hF000_0200, 32'h1, 0);
    d_read("rd_ext", 32'hF000_0100, 32'h1, 0);
    d_write("wr_print", 32'hF000_0000, 3'd2, 32'h41, 0);
    d_read("rd_print", 32'hF000_0000, 32'h0, 0);
    d_write("clr_soft", 32'hF000_0200, 3'd2, 32'h0, 0);
    d_write("clr_ext", 32'hF000_0100, 3'd2, 32'h0, 0);
    @(negedge clk);
    check("soft_irq_clr", 32'(soft_irq), 32'd0);
    check("ext_irq_clr", 32'(ext_irq), 32'd0);
    d_read("rd_soft_clr", 32'hF000_0200, 32'h0, 0);
    d_read("rd_ext_clr", 32'hF000_0100, 32'h0, 0);

    // Address wrap modulo 64 KiB.
    d_write("wr_wrap", 32'h0001_0004, 3'd2, 32'h5A5A_5A5A, 0);
    d_read("rd_wrap", 32'h0000_0004, 32'h5A5A_5A5A, 0);

    // All-ones pattern means zero waits; imem pattern 0b11 means two waits.
    dmem_stall = 32'hFFFF_FFFF;
    d_write("wr_ones", 32'h2000, 3'd2, 32'h0102_0304, 0);
    d_read("rd_ones", 32'h2000, 32'h0102_0304, 0);
    dmem_stall = 32'h0;
    imem_stall = 32'h3;
    i_read("imem_stall2", 32'h2000, 32'h0102_0304, 2);
    imem_stall = 32'h0;

    // Back-to-back write then read of the same word.
    @(negedge clk);
    dmem_htrans = 2'b10; dmem_haddr = 32'h400; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    dmem_hwdata = 32'hA5A5_0F0F; dmem_hwrite = 1'b0;
    exp_q.push_back(32'hA5A5_0F0F);
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    @(negedge clk);
    check("raw_hready", 32'(dmem_hready), 32'd1);
    check("raw_data", dmem_hrdata, exp_q.pop_front());

    // Same-cycle dmem write and imem read of one word.
    d_write("pre_300", 32'h300, 3'd2, 32'h1234_5678, 0);
    @(negedge clk);
    dmem_htrans = 2'b10; dmem_haddr = 32'h300; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
    imem_htrans = 2'b10; imem_haddr = 32'h300; imem_hsize = 3'd2;
    @(posedge clk); #1;
    dmem_htrans = 2'b00; imem_htrans = 2'b00; dmem_hwdata = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    check("dual_imem_data", imem_hrdata, exp_q.pop_front());
    check("dual_dmem_hready", 32'(dmem_hready), 32'd1);
    d_read("rd_300", 32'h300, 32'h0BAD_F00D, 0);

    // Reset in the middle of a stalled write drops it.
    d_write("set_soft", 32'hF000_0200, 3'd2, 32'h1, 0);
    dmem_stall = 32'h7;
    @(negedge clk);
    dmem_htrans = 2'b10; dmem_haddr = 32'h1000; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    dmem_htrans = 2'b00; dmem_hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("mid_wait_hready", 32'(dmem_hready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_hready", 32'(dmem_hready), 32'd1);
    check("mid_rst_hresp", 32'(dmem_hresp), 32'd0);
    check("mid_rst_soft_irq", 32'(soft_irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_stall = 32'h0;
    d_read("rd_after_rst", 32'h1000, 32'h11AB_CAFE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
